// File: rtl/wgt_buf_if.sv
// wgt_buf_if: bundles the weight-fill handshake, swap control and the active
// tap outputs of wgt_buf_bank. The slave modport is the buffer side; the master
// modport is the SRAM read path / controller side that drives the fill.
// Optional macro WGT_BUF_ZERO_MASK_EN adds the wgt_zero_mask output.
interface wgt_buf_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                      load_start;
  logic                      wgt_valid;
  logic                      wgt_ready;
  logic [DATA_W-1:0]         wgt_input;
  logic                      swap;
  logic [DEPTH*DATA_W-1:0]   wgt_taps;
  logic                      active_valid;
  logic                      shadow_full;
  logic [CNT_W-1:0]          fill_cnt;
  logic                      swap_done;
`ifdef WGT_BUF_ZERO_MASK_EN
  logic [DEPTH-1:0]          wgt_zero_mask;

  modport slave (
    input  load_start, wgt_valid, wgt_input, swap,
    output wgt_ready, wgt_taps, active_valid, shadow_full, fill_cnt, swap_done,
           wgt_zero_mask
  );

  modport master (
    output load_start, wgt_valid, wgt_input, swap,
    input  wgt_ready, wgt_taps, active_valid, shadow_full, fill_cnt, swap_done,
           wgt_zero_mask
  );
`else
  modport slave (
    input  load_start, wgt_valid, wgt_input, swap,
    output wgt_ready, wgt_taps, active_valid, shadow_full, fill_cnt, swap_done
  );

  modport master (
    output load_start, wgt_valid, wgt_input, swap,
    input  wgt_ready, wgt_taps, active_valid, shadow_full, fill_cnt, swap_done
  );
`endif

endinterface

// File: rtl/wgt_buf_bank.sv
// wgt_buf_bank: double-buffered weight shift buffer between the weight SRAM
// read path and the PE array. The shadow bank fills serially over a
// valid/ready handshake while the active bank keeps driving the PE taps; an
// explicit swap copies shadow to active so the next kernel loads stall-free.
// Optional macro WGT_BUF_ZERO_MASK_EN adds a registered per-tap zero mask that
// is loaded on the same edge as the taps.
module wgt_buf_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  wgt_buf_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                        state;
  state_t                        state_nxt;

  logic [DEPTH-1:0][DATA_W-1:0]  shadow_q;
  logic [DEPTH-1:0][DATA_W-1:0]  active_q;

  logic [CNT_W-1:0]              cnt_q;
  logic [CNT_W-1:0]              cnt_nxt;
  logic                          full_q;
  logic                          full_nxt;
  logic                          aval_q;
  logic                          aval_nxt;
  logic                          done_q;
  logic                          done_nxt;
  logic                          shift_en;
  logic                          swap_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, fill accounting and datapath enables
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    full_nxt  = full_q;
    aval_nxt  = aval_q;
    done_nxt  = 1'b0;
    shift_en  = 1'b0;
    swap_en   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end

      FILL: begin
        // ready is high for the whole state, so valid alone accepts a beat
        shift_en = bus.wgt_valid;
        if (bus.load_start) begin
          // a beat taken in the restart cycle is the first of the new fill
          cnt_nxt = shift_en ? CNT_W'(1) : '0;
        end else if (shift_en) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_nxt = FULL;
            full_nxt  = 1'b1;
          end
        end
      end

      FULL: begin
        if (bus.swap) begin
          swap_en   = 1'b1;
          aval_nxt  = 1'b1;
          full_nxt  = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = bus.load_start ? FILL : IDLE;
        end else if (bus.load_start) begin
          full_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        full_nxt  = 1'b0;
      end
    endcase
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      aval_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      full_q <= full_nxt;
      aval_q <= aval_nxt;
      done_q <= done_nxt;
    end
  end

  // Shadow bank: newest beat enters tap 0, older beats move up
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (shift_en) begin
      shadow_q <= {shadow_q[DEPTH-2:0], bus.wgt_input};
    end
  end

  // Active bank: loaded only by a completed swap, from pre-edge shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
    end else if (swap_en) begin
      active_q <= shadow_q;
    end
  end

`ifdef WGT_BUF_ZERO_MASK_EN
  logic [DEPTH-1:0] mask_q;
  logic [DEPTH-1:0] mask_nxt;

  // Per-tap zero detect on the shadow contents about to be swapped in
  always_comb begin
    mask_nxt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      mask_nxt[k] = (shadow_q[k] == '0);
    end
  end

  // Zero mask register, coherent with active_q (all-zero taps after reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else if (swap_en) begin
      mask_q <= mask_nxt;
    end
  end

  assign bus.wgt_zero_mask = mask_q;
`endif

  assign bus.wgt_ready    = (state == FILL);
  assign bus.wgt_taps     = active_q;
  assign bus.active_valid = aval_q;
  assign bus.shadow_full  = full_q;
  assign bus.fill_cnt     = cnt_q;
  assign bus.swap_done    = done_q;

endmodule
